// File: rtl/key_entry_pkg.sv
// Shared types and key code constants for the keypad entry block.
package key_entry_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_QUAL   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_QUAL = 2'd3
  } press_state_e;

  localparam logic [3:0] KEY_LAST_DIGIT = 4'h9;
  localparam logic [3:0] KEY_BKSP       = 4'hA;
  localparam logic [3:0] KEY_CLR        = 4'hB;
  localparam logic [3:0] KEY_ENTER      = 4'hC;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= KEY_LAST_DIGIT;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronizes the scanner's press level and qualifies press/release, emitting
// one combinational pulse (with the synchronized code) per physical press.
module key_debounce
  import key_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int RELEASE_CYCLES  = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid_i,
  input  logic [3:0] key_value_i,
  output logic       press_o,
  output logic [3:0] code_o
);

  localparam int CNT_MAX = (DEBOUNCE_CYCLES > RELEASE_CYCLES) ? DEBOUNCE_CYCLES : RELEASE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] REL_LAST = CW'(RELEASE_CYCLES - 1);

  logic          valid_meta_q, valid_sync_q;
  logic [3:0]    value_meta_q, value_sync_q;
  press_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_meta_q <= 1'b0;
      valid_sync_q <= 1'b0;
      value_meta_q <= 4'h0;
      value_sync_q <= 4'h0;
      // Start as if a release is pending so a key held across reset is ignored.
      state_q      <= ST_RELEASE_QUAL;
      cnt_q        <= '0;
    end else begin
      valid_meta_q <= key_valid_i;
      valid_sync_q <= valid_meta_q;
      value_meta_q <= key_value_i;
      value_sync_q <= value_meta_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
    end
  end

  // The cycle that leaves IDLE counts as the first qualified high (or low).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid_sync_q) begin
          if (DEBOUNCE_CYCLES <= 1) begin
            press_o = 1'b1;
            state_d = ST_HELD;
          end else begin
            state_d = ST_PRESS_QUAL;
            cnt_d   = CW'(1);
          end
        end
      end
      ST_PRESS_QUAL: begin
        if (!valid_sync_q) begin
          state_d = ST_IDLE;
        end else if (cnt_q >= DEB_LAST) begin
          press_o = 1'b1;
          state_d = ST_HELD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HELD: begin
        if (!valid_sync_q) begin
          state_d = (RELEASE_CYCLES <= 1) ? ST_IDLE : ST_RELEASE_QUAL;
          cnt_d   = CW'(1);
        end
      end
      ST_RELEASE_QUAL: begin
        if (valid_sync_q) begin
          state_d = ST_HELD;
        end else if (cnt_q >= REL_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_RELEASE_QUAL;
    endcase
  end

  assign code_o = value_sync_q;

endmodule

// File: rtl/key_entry.sv
// Keypad digit entry: BCD shift buffer with backspace/clear/enter editing.
// key_event and all buffer outputs appear 2+DEBOUNCE_CYCLES clk cycles after key_valid rises.
module key_entry
  import key_entry_pkg::*;
#(
  parameter int NDIGITS         = 8,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int RELEASE_CYCLES  = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 key_valid,
  input  logic [3:0]           key_value,
  output logic [4*NDIGITS-1:0] digits,
  output logic [3:0]           digit_count,
  output logic                 key_event,
  output logic [3:0]           key_code,
  output logic [4*NDIGITS-1:0] entry_value,
  output logic                 entry_valid,
  output logic                 overflow
);

  localparam int         W         = 4 * NDIGITS;
  localparam logic [3:0] MAX_COUNT = 4'(NDIGITS);

  logic       press;
  logic [3:0] press_code;

  logic [W-1:0] digits_q, digits_d;
  logic [3:0]   count_q, count_d;
  logic         key_event_q, key_event_d;
  logic [3:0]   key_code_q, key_code_d;
  logic [W-1:0] entry_value_q, entry_value_d;
  logic         entry_valid_q, entry_valid_d;
  logic         overflow_q, overflow_d;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RELEASE_CYCLES (RELEASE_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .reset      (reset),
    .key_valid_i(key_valid),
    .key_value_i(key_value),
    .press_o    (press),
    .code_o     (press_code)
  );

  always_comb begin
    digits_d      = digits_q;
    count_d       = count_q;
    key_event_d   = press;
    key_code_d    = key_code_q;
    entry_value_d = entry_value_q;
    entry_valid_d = 1'b0;
    overflow_d    = 1'b0;
    if (press) begin
      key_code_d = press_code;
      if (is_digit(press_code)) begin
        if (count_q < MAX_COUNT) begin
          digits_d = {digits_q[W-5:0], press_code};
          count_d  = count_q + 4'd1;
        end else begin
          overflow_d = 1'b1;
        end
      end else begin
        case (press_code)
          KEY_BKSP: begin
            if (count_q != 4'd0) begin
              digits_d = {4'h0, digits_q[W-1:4]};
              count_d  = count_q - 4'd1;
            end
          end
          KEY_CLR: begin
            digits_d = '0;
            count_d  = 4'd0;
          end
          KEY_ENTER: begin
            // An empty buffer is not a valid entry; leave everything untouched.
            if (count_q != 4'd0) begin
              entry_value_d = digits_q;
              entry_valid_d = 1'b1;
              digits_d      = '0;
              count_d       = 4'd0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits_q      <= '0;
      count_q       <= 4'd0;
      key_event_q   <= 1'b0;
      key_code_q    <= 4'h0;
      entry_value_q <= '0;
      entry_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      digits_q      <= digits_d;
      count_q       <= count_d;
      key_event_q   <= key_event_d;
      key_code_q    <= key_code_d;
      entry_value_q <= entry_value_d;
      entry_valid_q <= entry_valid_d;
      overflow_q    <= overflow_d;
    end
  end

  assign digits      = digits_q;
  assign digit_count = count_q;
  assign key_event   = key_event_q;
  assign key_code    = key_code_q;
  assign entry_value = entry_value_q;
  assign entry_valid = entry_valid_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_key_entry.sv
// Scoreboard bench for key_entry: stimulus queues expected events, a monitor checks them.
module tb_key_entry;
  import key_entry_pkg::*;

  localparam int N       = 8;
  localparam int D       = 4;
  localparam int R       = 4;
  localparam int EXP_LAT = 2 + D;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          key_valid = 1'b0;
  logic [3:0]    key_value = 4'h0;
  logic [4*N-1:0] digits;
  logic [3:0]    digit_count;
  logic          key_event;
  logic [3:0]    key_code;
  logic [4*N-1:0] entry_value;
  logic          entry_valid;
  logic          overflow;

  key_entry #(
    .NDIGITS        (N),
    .DEBOUNCE_CYCLES(D),
    .RELEASE_CYCLES (R)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_value  (key_value),
    .digits     (digits),
    .digit_count(digit_count),
    .key_event  (key_event),
    .key_code   (key_code),
    .entry_value(entry_value),
    .entry_valid(entry_valid),
    .overflow   (overflow)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [3:0]  code;
    logic [31:0] digits;
    logic [3:0]  count;
    logic        ovf;
    logic        ev;
    logic [31:0] eval;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;
  int   cyc;
  int   first_ev;

  function automatic void push(input logic [3:0] code, input logic [31:0] dig, input logic [3:0] cnt,
                               input logic ovf, input logic ev, input logic [31:0] eval);
    exp_t e;
    e.code = code; e.digits = dig; e.count = cnt; e.ovf = ovf; e.ev = ev; e.eval = eval;
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      if (key_event) begin
        vectors++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_event: got key_event code=%h digits=%h, required no event", key_code, digits);
        end else begin
          e = exp_q.pop_front();
          if (key_code !== e.code || digits !== e.digits || digit_count !== e.count ||
              overflow !== e.ovf || entry_valid !== e.ev || entry_value !== e.eval) begin
            errors++;
            $display("FAIL event_%h: got code=%h digits=%h count=%0d ovf=%b ev=%b eval=%h, required code=%h digits=%h count=%0d ovf=%b ev=%b eval=%h",
                     e.code, key_code, digits, digit_count, overflow, entry_valid, entry_value,
                     e.code, e.digits, e.count, e.ovf, e.ev, e.eval);
          end else begin
            $display("event code=%h digits=%h count=%0d ovf=%b ev=%b eval=%h ok",
                     key_code, digits, digit_count, overflow, entry_valid, entry_value);
          end
        end
      end else if (entry_valid || overflow) begin
        vectors++;
        errors++;
        $display("FAIL stray_pulse: got entry_valid=%b overflow=%b without key_event, required 0", entry_valid, overflow);
      end
    end
  end

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (key_event && first_ev == 0) first_ev = cyc;
    end
  endtask

  task automatic check_lat(input string name, input int exp_lat);
    vectors++;
    if (first_ev != exp_lat) begin
      errors++;
      $display("FAIL latency_%s: got %0d cycles, required %0d", name, first_ev, exp_lat);
    end else begin
      $display("press %s latency %0d ok", name, first_ev);
    end
  endtask

  task automatic press(input logic [3:0] code, input int hold, input int rel, input int exp_lat);
    key_value = code;
    key_valid = 1'b1;
    cyc = 0; first_ev = 0;
    run(hold);
    key_valid = 1'b0;
    run(rel);
    check_lat($sformatf("%h", code), exp_lat);
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] req);
    vectors++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end else begin
      $display("check %s = %h ok", name, got);
    end
  endtask

  logic [31:0] sevens [9] = '{32'h7, 32'h77, 32'h777, 32'h7777, 32'h77777, 32'h777777,
                              32'h7777777, 32'h77777777, 32'h77777777};

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_val("rst_digits", digits, 32'h0);
    check_val("rst_count", {28'h0, digit_count}, 32'h0);
    check_val("rst_key_code", {28'h0, key_code}, 32'h0);
    check_val("rst_entry_value", entry_value, 32'h0);
    check_val("rst_key_event", {31'h0, key_event}, 32'h0);
    check_val("rst_entry_valid", {31'h0, entry_valid}, 32'h0);
    check_val("rst_overflow", {31'h0, overflow}, 32'h0);
    run(8);  // let the post-reset release qualification finish

    // 1,2,3 then ENTER
    push(4'h1, 32'h1, 4'd1, 1'b0, 1'b0, 32'h0);   press(4'h1, 8, 10, EXP_LAT);
    push(4'h2, 32'h12, 4'd2, 1'b0, 1'b0, 32'h0);  press(4'h2, 8, 10, EXP_LAT);
    push(4'h3, 32'h123, 4'd3, 1'b0, 1'b0, 32'h0); press(4'h3, 8, 10, EXP_LAT);
    push(KEY_ENTER, 32'h0, 4'd0, 1'b0, 1'b1, 32'h123); press(KEY_ENTER, 8, 10, EXP_LAT);

    // short glitch press rejected, long hold gives one event
    press(4'h5, 2, 10, 0);
    push(4'h5, 32'h5, 4'd1, 1'b0, 1'b0, 32'h123); press(4'h5, 20, 10, EXP_LAT);
    push(KEY_CLR, 32'h0, 4'd0, 1'b0, 1'b0, 32'h123); press(KEY_CLR, 8, 10, EXP_LAT);

    // nine sevens: the ninth overflows
    for (int i = 0; i < 9; i++) begin
      push(4'h7, sevens[i], (i < 8) ? 4'(i + 1) : 4'd8, (i == 8), 1'b0, 32'h123);
      press(4'h7, 8, 10, EXP_LAT);
    end
    push(KEY_CLR, 32'h0, 4'd0, 1'b0, 1'b0, 32'h123); press(KEY_CLR, 8, 10, EXP_LAT);

    // backspace down through empty, then ENTER on empty
    push(4'h4, 32'h4, 4'd1, 1'b0, 1'b0, 32'h123);  press(4'h4, 8, 10, EXP_LAT);
    push(4'h5, 32'h45, 4'd2, 1'b0, 1'b0, 32'h123); press(4'h5, 8, 10, EXP_LAT);
    push(KEY_BKSP, 32'h4, 4'd1, 1'b0, 1'b0, 32'h123); press(KEY_BKSP, 8, 10, EXP_LAT);
    push(KEY_BKSP, 32'h0, 4'd0, 1'b0, 1'b0, 32'h123); press(KEY_BKSP, 8, 10, EXP_LAT);
    push(KEY_BKSP, 32'h0, 4'd0, 1'b0, 1'b0, 32'h123); press(KEY_BKSP, 8, 10, EXP_LAT);
    push(KEY_ENTER, 32'h0, 4'd0, 1'b0, 1'b0, 32'h123); press(KEY_ENTER, 8, 10, EXP_LAT);

    // key held across a reset that lands mid-qualification
    push(4'h8, 32'h8, 4'd1, 1'b0, 1'b0, 32'h123); press(4'h8, 8, 10, EXP_LAT);
    key_value = 4'h6;
    key_valid = 1'b1;
    cyc = 0; first_ev = 0;
    run(3);
    reset = 1'b1;
    run(3);
    reset = 1'b0;
    check_val("post_rst_digits", digits, 32'h0);
    check_val("post_rst_count", {28'h0, digit_count}, 32'h0);
    check_val("post_rst_key_code", {28'h0, key_code}, 32'h0);
    check_val("post_rst_entry_value", entry_value, 32'h0);
    run(10);
    key_valid = 1'b0;
    run(10);
    check_lat("held_across_reset", 0);
    push(4'h9, 32'h9, 4'd1, 1'b0, 1'b0, 32'h0); press(4'h9, 5, 10, EXP_LAT);

    // release glitch after a qualified press still yields one event
    push(KEY_CLR, 32'h0, 4'd0, 1'b0, 1'b0, 32'h0); press(KEY_CLR, 8, 10, EXP_LAT);
    push(4'h3, 32'h3, 4'd1, 1'b0, 1'b0, 32'h0);
    key_value = 4'h3;
    key_valid = 1'b1;
    cyc = 0; first_ev = 0;
    run(10);
    key_valid = 1'b0;
    run(2);
    key_valid = 1'b1;
    run(10);
    key_valid = 1'b0;
    run(10);
    check_lat("glitch_3", EXP_LAT);

    // non-editing code only reports itself
    push(4'hD, 32'h3, 4'd1, 1'b0, 1'b0, 32'h0); press(4'hD, 8, 10, EXP_LAT);

    run(4);
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d expected events never seen, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/key_entry.md
KEY_ENTRY -- requirements
Module: key_entry

Interface
REQ-001 Parameter NDIGITS, default 8: BCD digit capacity of the entry buffer.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000: consecutive clk cycles of synchronized key_valid high needed to accept a press.
REQ-003 Parameter RELEASE_CYCLES, default 1000: consecutive clk cycles of synchronized key_valid low needed to re-arm.
REQ-004 clk  input  1  50 MHz system clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 key_valid  input  1  press-held level from the keypad scanner; asynchronous to clk.
REQ-007 key_value  input  4  key code from the scanner; stable while key_valid is high.
REQ-008 digits  output  4*NDIGITS  live entry buffer; digits[3:0] is the most recent digit.
REQ-009 digit_count  output  4  number of digits held, 0..NDIGITS.
REQ-010 key_event  output  1  one-cycle pulse per accepted press.
REQ-011 key_code  output  4  code of the last accepted press; valid from key_event onward.
REQ-012 entry_value  output  4*NDIGITS  buffer contents latched on ENTER.
REQ-013 entry_valid  output  1  one-cycle pulse when entry_value updates.
REQ-014 overflow  output  1  one-cycle pulse when a digit arrives with the buffer full.

Function
REQ-015 key_valid passes through a 2-FF synchronizer; key_value is captured through its own 2-FF stage and sampled only once a press is qualified.
REQ-016 Press FSM states: IDLE, PRESS_QUAL, HELD, RELEASE_QUAL.
REQ-017 IDLE -> PRESS_QUAL when synced key_valid=1; counter cleared.
REQ-018 PRESS_QUAL: counter increments while synced key_valid=1; drop to 0 before DEBOUNCE_CYCLES -> IDLE with no event; reaching DEBOUNCE_CYCLES -> HELD.
REQ-019 On the PRESS_QUAL->HELD transition edge, key_event pulses, key_code loads, and the buffer update below is applied in the same cycle.
REQ-020 HELD -> RELEASE_QUAL when synced key_valid=0; RELEASE_QUAL -> IDLE after RELEASE_CYCLES consecutive lows; any high returns to HELD. Exactly one event is generated per physical press.
REQ-021 Codes 0x0-0x9 (digit): if digit_count<NDIGITS, shift buffer left 4 bits, insert code at [3:0], increment digit_count; if full, the buffer is unchanged and overflow pulses.
REQ-022 A leading digit 0 is stored and counted like any other digit.
REQ-023 Code 0xA (BACKSPACE): if digit_count>0, shift right 4 bits with 0 fill and decrement; at 0, no change.
REQ-024 Code 0xB (CLEAR): buffer=0, digit_count=0.
REQ-025 Code 0xC (ENTER): if digit_count>0, entry_value<=digits, entry_valid pulses, and the buffer and count clear in the same cycle; if digit_count=0, nothing happens and no pulse is issued.
REQ-026 Codes 0xD-0xF: key_event/key_code only; no buffer change.
REQ-027 Latency: key_event is asserted 2+DEBOUNCE_CYCLES(+1) clk cycles after the key_valid rise, fixed by implementation and documented; buffer, entry and overflow outputs are registered and coincide with key_event.

Reset
REQ-028 Reset clears digits, digit_count, key_code, entry_value, and all pulse outputs to 0, and clears the synchronizers.
REQ-029 The FSM leaves reset in RELEASE_QUAL, so a key held across reset produces no event until it is released and pressed again.
REQ-030 Reset asserted mid-qualification aborts the press; no partial event is issued.

Structure
REQ-031 Shared package key_entry_pkg holds the FSM state encoding and key code constants KEY_BKSP=0xA, KEY_CLR=0xB, KEY_ENTER=0xC.
REQ-032 Sub-module key_debounce contains the synchronizers, press FSM and counter, and outputs the press pulse and code; key_entry holds the buffer datapath.

Verification (DEBOUNCE_CYCLES=RELEASE_CYCLES=4, NDIGITS=8)
REQ-033 Keys 1,2,3 then ENTER -> digits 0x123 after the third press; ENTER gives entry_value=0x00000123, one entry_valid pulse, digit_count=0.
REQ-034 key_valid high for 2 cycles then low -> no key_event; a 20-cycle hold -> exactly one key_event.
REQ-035 Nine presses of digit 7 -> digits=0x77777777, count=8; the ninth press pulses overflow with the buffer unchanged.
REQ-036 Keys 4,5 then BKSP,BKSP,BKSP -> 0x4, then 0x0 with count 0; the third BKSP changes nothing. ENTER on empty -> no entry_valid.
REQ-037 Key held while reset deasserts -> no event; release, then a 5-cycle press of 9 -> key_event with key_code=9 and digits=0x9.
REQ-038 Key 3 followed by a 2-cycle release glitch and re-high -> still a single event, digits=0x3.
